// File: rtl/game_vga_timing.sv
// game_vga_timing: raster timing generator (pixel strobe, h/v counters, syncs, line/frame pulses).
// Latency: all outputs registered from next-state counter values, aligned with pixel_x/pixel_y
//   (GAME_VGA_TIMING_SYNC_DELAY_EN adds one clk to hsync/vsync/display_on only).
// Backpressure: none; free-running producer, consumers qualify on pixel_en.
module game_vga_timing #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pixel_en,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int XW1     = X_WIDTH + 1;
  localparam int YW1     = Y_WIDTH + 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [X_WIDTH-1:0] X_LAST     = X_WIDTH'(H_TOTAL - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST     = Y_WIDTH'(V_TOTAL - 1);
  // Compare constants are one bit wider than the counters so no bound truncates.
  localparam logic [XW1-1:0]     X_DISP     = XW1'(H_DISPLAY);
  localparam logic [XW1-1:0]     X_SYNC_BEG = XW1'(H_DISPLAY + H_FRONT);
  localparam logic [XW1-1:0]     X_SYNC_END = XW1'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [YW1-1:0]     Y_DISP     = YW1'(V_DISPLAY);
  localparam logic [YW1-1:0]     Y_SYNC_BEG = YW1'(V_DISPLAY + V_FRONT);
  localparam logic [YW1-1:0]     Y_SYNC_END = YW1'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic [XW1-1:0]     x_ext;
  logic [YW1-1:0]     y_ext;
  logic               adv;
  logic               en_q, en_d;
  logic               disp_q, disp_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;

  // Next-state counters and every output derived from the next-state coordinate,
  // so registered outputs land on the same edge as the counters.
  always_comb begin
    adv   = (div_q == DIV_LAST);
    div_d = adv ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (adv) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    x_ext  = {1'b0, x_d};
    y_ext  = {1'b0, y_d};
    en_d   = adv;
    disp_d = (x_ext < X_DISP) && (y_ext < Y_DISP);
    hs_d   = !((x_ext >= X_SYNC_BEG) && (x_ext < X_SYNC_END));
    vs_d   = !((y_ext >= Y_SYNC_BEG) && (y_ext < Y_SYNC_END));
    ls_d   = adv && (x_d == '0);
    fs_d   = ls_d && (y_d == '0);
  end

  // Counter and output registers; reset parks the raster on the last pixel so
  // the first advance lands on (0, 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= DIV_LAST;
      x_q    <= X_LAST;
      y_q    <= Y_LAST;
      en_q   <= 1'b0;
      disp_q <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      en_q   <= en_d;
      disp_q <= disp_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pixel_en    = en_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

`ifdef GAME_VGA_TIMING_SYNC_DELAY_EN
  logic disp_dq, hs_dq, vs_dq;

  // Extra stage lines syncs/blanking up with the registered rgb of the sprite stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_dq <= 1'b0;
      hs_dq   <= 1'b1;
      vs_dq   <= 1'b1;
    end else begin
      disp_dq <= disp_q;
      hs_dq   <= hs_q;
      vs_dq   <= vs_q;
    end
  end

  assign display_on = disp_dq;
  assign hsync      = hs_dq;
  assign vsync      = vs_dq;
`else
  assign display_on = disp_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
`endif

endmodule
